// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and control-state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_RSB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_ORR = 4'b0100;
  localparam logic [3:0] OP_EOR = 4'b0101;
  localparam logic [3:0] OP_BIC = 4'b0110;
  localparam logic [3:0] OP_MOV = 4'b0111;
  localparam logic [3:0] OP_MVN = 4'b1000;
  localparam logic [3:0] OP_ADC = 4'b1001;
  localparam logic [3:0] OP_SBC = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: W steps after start; done/P are presented
// combinationally during the final step so the parent can register them.
module alu_mul_iter #(
  parameter int W     = 8,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] P
);

  logic [W-1:0]     mcand_q;
  logic [W-1:0]     mplier_q;
  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [W-1:0]     acc_d;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= A;
      mplier_q <= B;
      acc_q    <= '0;
      cnt_q    <= CNT_W'(W);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CNT_W'(1));
  assign P    = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready input, registered result, persistent NZCV
// flags and an iterative multiply; one operation in flight at a time.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 8,
  localparam int CNT_W = $clog2(W) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ALUcontrol,
  input  logic         set_flags,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  output logic [W-1:0] Y,
  output logic         N,
  output logic         Z,
  output logic         CO,
  output logic         OVF,
  output logic         illegal
);

  state_e       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic         n_q, n_d, z_q, z_d, co_q, co_d, ovf_q, ovf_d;
  logic         illegal_q, illegal_d;
  logic         out_valid_q, out_valid_d;
  logic         mul_sf_q, mul_sf_d;

  logic         mul_start, mul_busy, mul_done;
  logic [W-1:0] mul_p;

  logic [W-1:0] add_x, add_y, logic_res;
  logic         add_cin, add_ovf;
  logic [W:0]   sum;

  // Subtractions are folded into one adder as X + ~Y + cin.
  always_comb begin
    add_x   = A;
    add_y   = B;
    add_cin = 1'b0;
    case (ALUcontrol)
      OP_SUB, OP_CMP: begin add_y = ~B; add_cin = 1'b1; end
      OP_RSB:         begin add_x = B; add_y = ~A; add_cin = 1'b1; end
      OP_ADC:         add_cin = co_q;
      OP_SBC:         begin add_y = ~B; add_cin = co_q; end
      default:        ;
    endcase
  end

  assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
  assign add_ovf = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);

  always_comb begin
    case (ALUcontrol)
      OP_AND:  logic_res = A & B;
      OP_ORR:  logic_res = A | B;
      OP_EOR:  logic_res = A ^ B;
      OP_BIC:  logic_res = A & ~B;
      OP_MVN:  logic_res = ~B;
      default: logic_res = B;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    n_d         = n_q;
    z_d         = z_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    mul_sf_d    = mul_sf_q;
    mul_start   = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        out_valid_d = 1'b1;
        illegal_d   = 1'b0;
        case (ALUcontrol)
          OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC, OP_CMP: begin
            if (ALUcontrol != OP_CMP) y_d = sum[W-1:0];
            if (set_flags || ALUcontrol == OP_CMP) begin
              n_d   = sum[W-1];
              z_d   = (sum[W-1:0] == '0);
              co_d  = sum[W];
              ovf_d = add_ovf;
            end
          end
          OP_AND, OP_ORR, OP_EOR, OP_BIC, OP_MOV, OP_MVN: begin
            y_d = logic_res;
            if (set_flags) begin
              n_d = logic_res[W-1];
              z_d = (logic_res == '0);
            end
          end
          OP_MUL: begin
            out_valid_d = 1'b0;
            illegal_d   = illegal_q;
            state_d     = S_BUSY;
            mul_start   = 1'b1;
            mul_sf_d    = set_flags;
          end
          default: begin
            y_d       = '0;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_BUSY: if (mul_done) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        illegal_d   = 1'b0;
        y_d         = mul_p;
        if (mul_sf_q) begin
          n_d = mul_p[W-1];
          z_d = (mul_p == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      y_q         <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      mul_sf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      n_q         <= n_d;
      z_q         <= z_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      mul_sf_q    <= mul_sf_d;
    end
  end

  alu_mul_iter #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .A     (A),
    .B     (B),
    .busy  (mul_busy),
    .done  (mul_done),
    .P     (mul_p)
  );

  assign in_ready  = (state_q == S_IDLE) && !mul_busy;
  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign CO        = co_q;
  assign OVF       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=8): integer-arithmetic reference model with a
// per-cycle compare process, plus literal checks pinning the test-plan cases.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ALUcontrol;
  logic       set_flags;
  logic [7:0] A, B;
  logic       out_valid;
  logic [7:0] Y;
  logic       N, Z, CO, OVF, illegal;

  alu_seq #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUcontrol (ALUcontrol),
    .set_flags  (set_flags),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .Y          (Y),
    .N          (N),
    .Z          (Z),
    .CO         (CO),
    .OVF        (OVF),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    else
      pass_cnt++;
  endtask

  // Reference model: architectural state after each accepted op, plus
  // the registered values currently visible on the outputs.
  typedef struct {
    int         due;
    logic [7:0] y;
    logic       n, z, c, v, ill;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_y = 0;
  logic       m_n = 0, m_z = 0, m_c = 0, m_v = 0, m_ill = 0;
  logic [7:0] sh_y = 0;
  logic       sh_n = 0, sh_z = 0, sh_c = 0, sh_v = 0, sh_ill = 0;
  int         busy_until = 0;

  task automatic model_reset();
    exp_q.delete();
    m_y = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_ill = 0;
    sh_y = 0; sh_n = 0; sh_z = 0; sh_c = 0; sh_v = 0; sh_ill = 0;
    busy_until = cyc;
  endtask

  task automatic model_accept(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input bit sf, input int k);
    int ua, ub, sa, sb, r, s, cin;
    bit arith, lg, is_add;
    logic [7:0] res;
    exp_t e;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); cin = m_c;
    r = 0; s = 0; arith = 0; lg = 0; is_add = 0;
    case (op)
      OP_ADD: begin r = ua + ub; s = sa + sb; arith = 1; is_add = 1; end
      OP_ADC: begin r = ua + ub + cin; s = sa + sb + cin; arith = 1; is_add = 1; end
      OP_SUB, OP_CMP: begin r = ua - ub; s = sa - sb; arith = 1; end
      OP_RSB: begin r = ub - ua; s = sb - sa; arith = 1; end
      OP_SBC: begin r = ua - ub - 1 + cin; s = sa - sb - 1 + cin; arith = 1; end
      OP_AND: begin r = ua & ub; lg = 1; end
      OP_ORR: begin r = ua | ub; lg = 1; end
      OP_EOR: begin r = ua ^ ub; lg = 1; end
      OP_BIC: begin r = ua & (255 - ub); lg = 1; end
      OP_MOV: begin r = ub; lg = 1; end
      OP_MVN: begin r = 255 - ub; lg = 1; end
      OP_MUL: begin r = (ua * ub) % 256; lg = 1; end
      default: ;
    endcase
    res = r[7:0];
    if (!arith && !lg) begin
      m_y = 0; m_ill = 1;
    end else begin
      m_ill = 0;
      if (op != OP_CMP) m_y = res;
      if (sf || op == OP_CMP) begin
        m_n = res[7];
        m_z = (res == 0);
        if (arith) begin
          m_c = is_add ? (r > 255) : (r >= 0);
          m_v = (s > 127) || (s < -128);
        end
      end
    end
    e.due = (op == OP_MUL) ? k + 8 : k;
    e.y = m_y; e.n = m_n; e.z = m_z; e.c = m_c; e.v = m_v; e.ill = m_ill;
    exp_q.push_back(e);
    if (op == OP_MUL) busy_until = k + 8;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", out_valid, ev);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        sh_y = exp_q[0].y; sh_n = exp_q[0].n; sh_z = exp_q[0].z;
        sh_c = exp_q[0].c; sh_v = exp_q[0].v; sh_ill = exp_q[0].ill;
        void'(exp_q.pop_front());
      end
      chk("Y", Y, sh_y);
      chk("N", N, sh_n);
      chk("Z", Z, sh_z);
      chk("CO", CO, sh_c);
      chk("OVF", OVF, sh_v);
      chk("illegal", illegal, sh_ill);
      chk("in_ready", in_ready, cyc >= busy_until);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit sf);
    int g;
    g = 0;
    while (cyc < busy_until) begin
      @(posedge clk); #1;
      g++;
      if (g > 50) begin
        chk("busy_timeout", 1, 0);
        break;
      end
    end
    ALUcontrol = op; A = a; B = b; set_flags = sf; in_valid = 1'b1;
    @(posedge clk); #1;
    model_accept(op, a, b, sf, cyc);
    $display("op=%b A=%02h B=%02h sf=%0d accepted at cycle %0d", op, a, b, sf, cyc);
    in_valid = 1'b0;
  endtask

  task automatic lit_flags(input string nm, input logic [7:0] y, input logic n, input logic z,
                           input logic c, input logic v);
    chk({nm, "_Y"}, Y, y);
    chk({nm, "_N"}, N, n);
    chk({nm, "_Z"}, Z, z);
    chk({nm, "_CO"}, CO, c);
    chk({nm, "_OVF"}, OVF, v);
  endtask

  initial begin
    int nb;
    rst = 1'b0; in_valid = 1'b0; ALUcontrol = '0; set_flags = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    lit_flags("reset", 8'h00, 0, 0, 0, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_illegal", illegal, 0);
    chk("reset_in_ready", in_ready, 1);
    model_reset();
    rst = 1'b1;
    chk_en = 1'b1;

    issue(OP_ADD, 8'h7F, 8'h01, 1);
    chk("add_ovf_valid", out_valid, 1);
    lit_flags("add_ovf", 8'h80, 1, 0, 0, 1);

    issue(OP_SUB, 8'h05, 8'h05, 1);
    lit_flags("sub_eq", 8'h00, 0, 1, 1, 0);
    issue(OP_SUB, 8'h00, 8'h01, 1);
    lit_flags("sub_borrow", 8'hFF, 1, 0, 0, 0);

    issue(OP_ADD, 8'hFF, 8'h01, 1);
    lit_flags("add_carry", 8'h00, 0, 1, 1, 0);
    issue(OP_ADC, 8'h01, 8'h01, 1);
    lit_flags("adc", 8'h03, 0, 0, 0, 0);
    issue(OP_AND, 8'hF0, 8'h0F, 0);
    lit_flags("and_noflags", 8'h00, 0, 0, 0, 0);

    issue(OP_RSB, 8'h10, 8'h30, 1);
    issue(OP_ORR, 8'h81, 8'h10, 1);
    issue(OP_EOR, 8'hAA, 8'hAA, 1);
    issue(OP_BIC, 8'hFF, 8'h0F, 1);
    issue(OP_MVN, 8'h00, 8'hFF, 1);
    issue(OP_SBC, 8'h10, 8'h01, 1);
    issue(OP_SBC, 8'h80, 8'h01, 1);
    issue(OP_ADD, 8'h80, 8'h80, 1);
    lit_flags("add_neg_ovf", 8'h00, 0, 1, 1, 1);

    // MUL with a competing request held high through BUSY.
    issue(OP_MUL, 8'h0F, 8'h11, 1);
    ALUcontrol = OP_ADD; A = 8'h01; B = 8'h01; set_flags = 1'b1; in_valid = 1'b1;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (!in_ready) nb++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", nb, 8);
    chk("mul_valid_at_8", out_valid, 1);
    lit_flags("mul", 8'hFF, 1, 0, 1, 1);

    // Reset in the third cycle of a multiply.
    @(posedge clk); #1;
    issue(OP_MUL, 8'h03, 8'h03, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
    chk("rst_mul_out_valid", out_valid, 0);
    chk("rst_mul_in_ready", in_ready, 1);
    lit_flags("rst_mul", 8'h00, 0, 0, 0, 0);
    issue(OP_ADD, 8'h02, 8'h03, 1);
    lit_flags("add_after_rst", 8'h05, 0, 0, 0, 0);

    issue(OP_CMP, 8'h03, 8'h07, 0);
    chk("cmp_valid", out_valid, 1);
    lit_flags("cmp", 8'h05, 1, 0, 0, 0);
    issue(4'b1110, 8'h12, 8'h34, 1);
    chk("rsvd_valid", out_valid, 1);
    chk("rsvd_illegal", illegal, 1);
    lit_flags("rsvd", 8'h00, 1, 0, 0, 0);
    issue(4'b1101, 8'h01, 8'h01, 1);
    issue(4'b1111, 8'h01, 8'h01, 0);
    issue(OP_MOV, 8'h00, 8'h5A, 0);
    chk("legal_clears_illegal", illegal, 0);
    chk("mov_Y", Y, 8'h5A);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
